// File: rtl/wb_sdram_arbiter.sv
// Round-robin arbiter sharing one Wishbone B3 SDRAM controller port among masters.
// Optional bus watchdog enabled by defining WB_SDRAM_ARB_TIMEOUT_EN.
module wb_sdram_arbiter #(
  parameter int NUM_MASTERS    = 2,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  input  logic [NUM_MASTERS*AW-1:0] m_adr_i,
  input  logic [NUM_MASTERS*DW-1:0] m_dat_i,
  input  logic [NUM_MASTERS*DW/8-1:0] m_sel_i,
  input  logic [NUM_MASTERS-1:0]    m_we_i,
  input  logic [NUM_MASTERS-1:0]    m_cyc_i,
  input  logic [NUM_MASTERS-1:0]    m_stb_i,
  input  logic [NUM_MASTERS*3-1:0]  m_cti_i,
  input  logic [NUM_MASTERS*2-1:0]  m_bte_i,
  output logic [DW-1:0]             m_dat_o,
  output logic [NUM_MASTERS-1:0]    m_ack_o,
  output logic [NUM_MASTERS-1:0]    m_err_o,
  output logic [AW-1:0]             s_adr_o,
  output logic [DW-1:0]             s_dat_o,
  output logic [DW/8-1:0]           s_sel_o,
  output logic                      s_we_o,
  output logic                      s_cyc_o,
  output logic                      s_stb_o,
  output logic [2:0]                s_cti_o,
  output logic [1:0]                s_bte_o,
  input  logic [DW-1:0]             s_dat_i,
  input  logic                      s_ack_i,
  input  logic                      s_err_i,
  output logic [NUM_MASTERS-1:0]    grant_o
);

  localparam int SW = DW / 8;
  localparam int IW = $clog2(NUM_MASTERS);

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                 r_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [IW-1:0]          r_last;
  logic [IW-1:0]          r_gidx;
  logic [IW-1:0]          w_win;
  logic [IW-1:0]          w_cand;
  logic                   w_found;
  logic                   w_to;

  // Scan last+1, last+2, ... so the previous owner is considered last.
  always_comb begin
    w_win   = '0;
    w_cand  = '0;
    w_found = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      w_cand = IW'((int'(r_last) + k) % NUM_MASTERS);
      if (!w_found && m_cyc_i[w_cand]) begin
        w_found = 1'b1;
        w_win   = w_cand;
      end
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= IW'(NUM_MASTERS - 1);
      r_gidx  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_grant <= NUM_MASTERS'(1) << w_win;
            r_gidx  <= w_win;
            r_state <= OWNED;
          end
        end
        OWNED: begin
          if (!m_cyc_i[r_gidx] || w_to) begin
            r_grant <= '0;
            r_last  <= r_gidx;
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

`ifdef WB_SDRAM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;

  assign w_to = (r_state == OWNED) && (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || r_state != OWNED || s_ack_i || s_err_i || w_to)
      r_cnt <= '0;
    else if (s_cyc_o && s_stb_o)
      r_cnt <= r_cnt + CW'(1);
  end
`else
  assign w_to = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif

  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (r_grant[i]) begin
        s_adr_o = m_adr_i[i*AW +: AW];
        s_dat_o = m_dat_i[i*DW +: DW];
        s_sel_o = m_sel_i[i*SW +: SW];
        s_we_o  = m_we_i[i];
        s_cyc_o = m_cyc_i[i];
        s_stb_o = m_stb_i[i];
        s_cti_o = m_cti_i[i*3 +: 3];
        s_bte_o = m_bte_i[i*2 +: 2];
      end
    end
    if (w_to) begin
      s_cyc_o = 1'b0;
      s_stb_o = 1'b0;
    end
  end

  assign m_dat_o = s_dat_i;
  assign m_ack_o = (s_ack_i && !wb_rst_i) ? r_grant : '0;
  assign m_err_o = ((s_err_i || w_to) && !wb_rst_i) ? r_grant : '0;
  assign grant_o = r_grant;

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Bench for wb_sdram_arbiter: directed scenarios plus randomized traffic
// checked against a round-robin ownership model.
module tb_wb_sdram_arbiter;

  localparam int N  = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*AW-1:0] m_adr;
  logic [N*DW-1:0] m_dat;
  logic [N*SW-1:0] m_sel;
  logic [N-1:0]    m_we, m_cyc, m_stb;
  logic [N*3-1:0]  m_cti;
  logic [N*2-1:0]  m_bte;
  logic [DW-1:0]   m_dat_o;
  logic [N-1:0]    m_ack, m_err, grant;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat_o, s_dat_i;
  logic [SW-1:0]   s_sel;
  logic            s_we, s_cyc, s_stb, s_ack, s_err;
  logic [2:0]      s_cti;
  logic [1:0]      s_bte;

  int checks = 0;
  int failures = 0;
  int own = -1;
  int last = N - 1;

  always #5 clk = ~clk;

  wb_sdram_arbiter #(
    .NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel),
    .m_we_i(m_we), .m_cyc_i(m_cyc), .m_stb_i(m_stb),
    .m_cti_i(m_cti), .m_bte_i(m_bte),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack), .m_err_o(m_err),
    .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_sel_o(s_sel),
    .s_we_o(s_we), .s_cyc_o(s_cyc), .s_stb_o(s_stb),
    .s_cti_o(s_cti), .s_bte_o(s_bte),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack), .s_err_i(s_err),
    .grant_o(grant)
  );

  function automatic int rr_pick(int lst, logic [N-1:0] req);
    for (int k = 1; k <= N; k++)
      if (req[(lst + k) % N]) return (lst + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_grant();
    return (own < 0) ? '0 : (N'(1) << own);
  endfunction

  // Advance one clock; the model sees the inputs present at the edge.
  task automatic step();
    logic [N-1:0] req;
    logic r;
    req = m_cyc;
    r = rst;
    @(posedge clk);
    if (r) begin
      own = -1;
      last = N - 1;
    end else if (own < 0) begin
      own = rr_pick(last, req);
    end else if (!req[own]) begin
      last = own;
      own = -1;
    end
    #1;
  endtask

  task automatic set_m(int i, logic cyc, logic stb, logic [2:0] cti);
    m_cyc[i] = cyc;
    m_stb[i] = stb;
    m_cti[i*3 +: 3] = cti;
  endtask

  task automatic clear_all();
    m_cyc = '0; m_stb = '0; m_we = '0; m_cti = '0; m_bte = '0;
    s_ack = 0; s_err = 0;
  endtask

  task automatic test_reset();
    clear_all();
    m_adr = '0; m_dat = '0; m_sel = '0; s_dat_i = '0;
    rst = 1; s_ack = 1;
    #1;
    checks++;
    if (m_ack !== '0) begin
      failures++; $display("FAIL rst_ack got=%b exp=0", m_ack);
    end
    step(); step();
    checks++;
    if (grant !== '0 || s_cyc !== 1'b0) begin
      failures++; $display("FAIL rst_state grant=%b s_cyc=%b exp=0", grant, s_cyc);
    end
    rst = 0;
    step();
    checks++;
    if (grant !== '0 || m_ack !== '0) begin
      failures++; $display("FAIL idle_ack grant=%b ack=%b exp=0", grant, m_ack);
    end
    s_ack = 0;
  endtask

  task automatic test_single_read();
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    a = AW'($urandom); d = $urandom;
    set_m(0, 1, 0, 3'b000); set_m(1, 1, 0, 3'b000);
    step();
    checks++;
    if (grant !== 4'b0001) begin
      failures++; $display("FAIL first_grant got=%b exp=0001", grant);
    end
    m_stb[0] = 1; m_adr[0 +: AW] = a; s_dat_i = d; s_ack = 1;
    #1;
    checks++;
    if (m_ack !== 4'b0001 || m_dat_o !== d || s_adr !== a || s_stb !== 1'b1) begin
      failures++;
      $display("FAIL read ack=%b dat=%h adr=%h stb=%b exp 0001 %h %h 1",
               m_ack, m_dat_o, s_adr, s_stb, d, a);
    end
    step();
    s_ack = 0; set_m(0, 0, 0, 3'b000);
    step();
    checks++;
    if (grant !== '0 || s_cyc !== 1'b0) begin
      failures++; $display("FAIL dead_cycle grant=%b s_cyc=%b exp=0", grant, s_cyc);
    end
    step();
    checks++;
    if (grant !== 4'b0010 || s_cyc !== 1'b1) begin
      failures++; $display("FAIL handover grant=%b s_cyc=%b exp=0010 1", grant, s_cyc);
    end
    set_m(1, 0, 0, 3'b000);
    step(); step();
  endtask

  task automatic test_burst();
    logic [2:0] ctis [4];
    ctis[0] = 3'b010; ctis[1] = 3'b010; ctis[2] = 3'b010; ctis[3] = 3'b111;
    set_m(0, 1, 0, 3'b000); set_m(1, 1, 0, 3'b000);
    step();
    checks++;
    if (grant !== 4'b0001) begin
      failures++; $display("FAIL burst_grant got=%b exp=0001", grant);
    end
    for (int b = 0; b < 4; b++) begin
      set_m(0, 1, 1, ctis[b]);
      m_adr[0 +: AW] = AW'(16'h0100 + 4 * b);
      s_ack = 1;
      #1;
      checks++;
      if (m_ack !== 4'b0001 || s_cti !== ctis[b] || grant !== 4'b0001) begin
        failures++;
        $display("FAIL burst_beat%0d ack=%b cti=%b grant=%b exp 0001 %b 0001",
                 b, m_ack, s_cti, grant, ctis[b]);
      end
      step();
    end
    s_ack = 0; set_m(0, 0, 0, 3'b000);
    step();
    checks++;
    if (grant !== '0) begin
      failures++; $display("FAIL burst_release got=%b exp=0000", grant);
    end
    step();
    checks++;
    if (grant !== 4'b0010) begin
      failures++; $display("FAIL burst_next got=%b exp=0010", grant);
    end
    set_m(1, 0, 0, 3'b000);
    step(); step();
  endtask

  task automatic test_rr4();
    int order [5];
    order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
    rst = 1; step(); rst = 0;
    m_cyc = '1;
    for (int j = 0; j < 5; j++) begin
      step();
      checks++;
      if (grant !== (N'(1) << order[j]) || grant !== exp_grant()) begin
        failures++;
        $display("FAIL rr_order%0d got=%b exp_master=%0d", j, grant, order[j]);
      end
      m_stb[order[j]] = 1; s_ack = 1;
      #1;
      checks++;
      if (m_ack !== (N'(1) << order[j])) begin
        failures++; $display("FAIL rr_ack%0d got=%b exp=%b", j, m_ack, N'(1) << order[j]);
      end
      step();
      s_ack = 0; m_stb[order[j]] = 0; m_cyc[order[j]] = 0;
      step();
      m_cyc[order[j]] = 1;
    end
    clear_all();
    step();
  endtask

  task automatic test_reset_mid();
    set_m(1, 1, 0, 3'b000);
    step();
    checks++;
    if (grant !== 4'b0010) begin
      failures++; $display("FAIL rm_grant got=%b exp=0010", grant);
    end
    set_m(1, 1, 1, 3'b010); s_ack = 1;
    step();
    rst = 1;
    #1;
    checks++;
    if (m_ack !== '0 || m_err !== '0) begin
      failures++; $display("FAIL rm_ack_in_rst ack=%b err=%b exp=0", m_ack, m_err);
    end
    step();
    checks++;
    if (grant !== '0 || s_cyc !== 1'b0) begin
      failures++; $display("FAIL rm_drop grant=%b s_cyc=%b exp=0", grant, s_cyc);
    end
    rst = 0; s_ack = 0;
    set_m(0, 1, 0, 3'b000);
    step();
    checks++;
    if (grant !== 4'b0001) begin
      failures++; $display("FAIL rm_favour0 got=%b exp=0001", grant);
    end
    clear_all();
    step(); step();
  endtask

  task automatic test_stall();
    set_m(2, 1, 1, 3'b000); s_ack = 0;
    step();
    checks++;
    if (grant !== 4'b0100) begin
      failures++; $display("FAIL stall_grant got=%b exp=0100", grant);
    end
`ifdef WB_SDRAM_ARB_TIMEOUT_EN
    for (int n = 1; n <= TO; n++) begin
      checks++;
      if (n < TO && (m_err !== '0 || s_cyc !== 1'b1)) begin
        failures++; $display("FAIL stall_early%0d err=%b s_cyc=%b exp 0 1", n, m_err, s_cyc);
      end else if (n == TO && (m_err !== 4'b0100 || s_cyc !== 1'b0)) begin
        failures++; $display("FAIL stall_to err=%b s_cyc=%b exp 0100 0", m_err, s_cyc);
      end
      step();
    end
    own = -1; last = 2;
    checks++;
    if (grant !== '0) begin
      failures++; $display("FAIL stall_idle got=%b exp=0000", grant);
    end
`else
    for (int n = 0; n < 3 * TO; n++) begin
      checks++;
      if (grant !== 4'b0100 || m_err !== '0 || s_cyc !== 1'b1) begin
        failures++;
        $display("FAIL stall_hold%0d grant=%b err=%b s_cyc=%b exp 0100 0 1",
                 n, grant, m_err, s_cyc);
      end
      step();
    end
`endif
    clear_all();
    step(); step();
  endtask

  task automatic test_random();
    int sc;
    logic [N-1:0] eg;
    sc = 0;
    rst = 1; clear_all(); step(); rst = 0;
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) begin
        if (m_cyc[i]) m_cyc[i] = ($urandom_range(3) != 0);
        else          m_cyc[i] = ($urandom_range(2) == 0);
        m_stb[i] = m_cyc[i] & 1'($urandom);
        m_we[i]  = 1'($urandom);
      end
      m_adr = {N{AW'($urandom)}} ^ (N*AW)'($urandom);
      m_dat = {$urandom, $urandom, $urandom, $urandom};
      m_sel = (N*SW)'($urandom);
      s_dat_i = $urandom;
      s_ack = 1'($urandom);
      s_err = ($urandom_range(15) == 0);
      if (own >= 0 && sc >= 10) s_ack = 1;
      #1;
      eg = exp_grant();
      checks++;
      if (grant !== eg) begin
        failures++; $display("FAIL rnd_grant t=%0d got=%b exp=%b", t, grant, eg);
      end
      checks++;
      if (s_cyc !== (own >= 0 ? m_cyc[own] : 1'b0) ||
          s_stb !== (own >= 0 ? m_stb[own] : 1'b0)) begin
        failures++; $display("FAIL rnd_cycstb t=%0d cyc=%b stb=%b own=%0d", t, s_cyc, s_stb, own);
      end
      checks++;
      if (s_adr !== (own >= 0 ? m_adr[own*AW +: AW] : '0) ||
          s_dat_o !== (own >= 0 ? m_dat[own*DW +: DW] : '0) ||
          s_we !== (own >= 0 ? m_we[own] : 1'b0)) begin
        failures++; $display("FAIL rnd_mux t=%0d adr=%h dat=%h own=%0d", t, s_adr, s_dat_o, own);
      end
      checks++;
      if (m_ack !== (s_ack ? eg : '0) || m_err !== (s_err ? eg : '0)) begin
        failures++;
        $display("FAIL rnd_term t=%0d ack=%b err=%b exp %b %b",
                 t, m_ack, m_err, s_ack ? eg : '0, s_err ? eg : '0);
      end
      checks++;
      if (m_dat_o !== s_dat_i) begin
        failures++; $display("FAIL rnd_rdata t=%0d got=%h exp=%h", t, m_dat_o, s_dat_i);
      end
      if (own < 0 || s_ack || s_err) sc = 0;
      else if (m_cyc[own] && m_stb[own]) sc++;
      step();
      if (own < 0) sc = 0;
    end
    clear_all();
    step(); step();
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_read();
    test_burst();
    test_rr4();
    test_reset_mid();
    test_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
